// File: rtl/interleaver_pkg.sv
// Shared defaults, FSM state encodings and the per-bank block descriptor
// for the QPP interleaver ping-pong controller.
package interleaver_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int MIN_K_DEF  = 40;
  localparam int MAX_K_DEF  = 6144;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PRIME,
    R_DRAIN
  } rd_state_e;

  // Block descriptor at the default address width.
  typedef struct packed {
    logic [ADDR_W_DEF:0]   k;
    logic [ADDR_W_DEF-1:0] f1;
    logic [ADDR_W_DEF-1:0] f2;
  } blk_desc_t;

endpackage

// File: rtl/qpp_addr_gen.sv
// Incremental QPP address generator: pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*f2,
// every step reduced mod K with a single conditional subtract.
module qpp_addr_gen #(
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W:0]   k_i,
  input  logic [ADDR_W-1:0] f1_i,
  input  logic [ADDR_W-1:0] f2_i,
  input  logic              init_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W:0] pi_q, pi_d;
  logic [ADDR_W:0] g_q, g_d;
  logic [ADDR_W:0] s_q, s_d;

  // Operands are already below K, so their sum is below 2K.
  function automatic logic [ADDR_W:0] mod_add(input logic [ADDR_W:0] a,
                                              input logic [ADDR_W:0] b,
                                              input logic [ADDR_W:0] k);
    logic [ADDR_W+1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, k}) sum = sum - {1'b0, k};
    return sum[ADDR_W:0];
  endfunction

  always_comb begin
    pi_d = pi_q;
    g_d  = g_q;
    s_d  = s_q;
    if (init_i) begin
      pi_d = '0;
      g_d  = mod_add({1'b0, f1_i}, {1'b0, f2_i}, k_i);
      s_d  = mod_add({1'b0, f2_i}, {1'b0, f2_i}, k_i);
    end else if (step_i) begin
      pi_d = mod_add(pi_q, g_q, k_i);
      g_d  = mod_add(g_q, s_q, k_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pi_q <= '0;
      g_q  <= '0;
      s_q  <= '0;
    end else begin
      pi_q <= pi_d;
      g_q  <= g_d;
      s_q  <= s_d;
    end
  end

  assign addr_o = pi_q[ADDR_W-1:0];

endmodule

// File: rtl/interleaver_ctrl.sv
// Ping-pong QPP interleaver controller: sequential writes into one RAM bank
// while the other bank is read back in QPP order through an RD_LAT valid pipe.
module interleaver_ctrl
  import interleaver_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MIN_K  = MIN_K_DEF,
  parameter int MAX_K  = MAX_K_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W:0]   blk_len_i,
  input  logic [ADDR_W-1:0] f1_i,
  input  logic [ADDR_W-1:0] f2_i,
  output logic              wr_en_o,
  output logic              wr_bank_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              rd_en_o,
  output logic              rd_bank_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              out_valid_o,
  output logic              out_last_o,
  output logic              done_o,
  output logic              err_o
);

  typedef struct packed {
    logic [ADDR_W:0]   k;
    logic [ADDR_W-1:0] f1;
    logic [ADDR_W-1:0] f2;
  } desc_t;

  localparam logic [ADDR_W:0]   K_MIN = MIN_K[ADDR_W:0];
  localparam logic [ADDR_W:0]   K_MAX = MAX_K[ADDR_W:0];
  localparam logic [ADDR_W:0]   ONE_K = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  desc_t             desc_q [2];
  logic [RD_LAT-1:0] vld_pipe_q, last_pipe_q;

  logic  accept, len_ok, desc_load, rd_last, gen_init, gen_step;
  desc_t rd_desc;

  assign in_ready_o = !full_q[wr_bank_q];
  assign accept     = in_valid_i && in_ready_o;
  assign len_ok     = (blk_len_i >= K_MIN) && (blk_len_i <= K_MAX);
  assign rd_desc    = desc_q[rd_bank_q];

  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_addr_d  = wr_addr_q;
    rd_idx_d   = rd_idx_q;
    wr_en_o    = 1'b0;
    err_o      = 1'b0;
    rd_en_o    = 1'b0;
    desc_load  = 1'b0;
    gen_init   = 1'b0;
    gen_step   = 1'b0;
    rd_last    = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        if (accept && start_i) begin
          if (len_ok) begin
            desc_load  = 1'b1;
            wr_en_o    = 1'b1;
            wr_addr_d  = ONE_A;
            wr_state_d = W_FILL;
          end else begin
            err_o = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (accept) begin
          wr_en_o = 1'b1;
          if ({1'b0, wr_addr_q} == desc_q[wr_bank_q].k - ONE_K) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_addr_d         = '0;
            wr_state_d        = W_IDLE;
          end else begin
            wr_addr_d = wr_addr_q + ONE_A;
          end
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    // Write-side set and read-side clear always target different banks.
    case (rd_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) rd_state_d = R_PRIME;
      end
      R_PRIME: begin
        gen_init   = 1'b1;
        rd_idx_d   = '0;
        rd_state_d = R_DRAIN;
      end
      R_DRAIN: begin
        rd_en_o  = 1'b1;
        gen_step = 1'b1;
        if (rd_idx_q == rd_desc.k - ONE_K) begin
          rd_last           = 1'b1;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
          rd_state_d        = R_IDLE;
        end else begin
          rd_idx_d = rd_idx_q + ONE_K;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_state_q  <= W_IDLE;
      rd_state_q  <= R_IDLE;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_idx_q    <= '0;
      desc_q[0]   <= '0;
      desc_q[1]   <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_addr_q  <= wr_addr_d;
      rd_idx_q   <= rd_idx_d;
      if (desc_load) desc_q[wr_bank_q] <= '{k: blk_len_i, f1: f1_i, f2: f2_i};
      vld_pipe_q[0]  <= rd_en_o;
      last_pipe_q[0] <= rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  qpp_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .k_i    (rd_desc.k),
    .f1_i   (rd_desc.f1),
    .f2_i   (rd_desc.f2),
    .init_i (gen_init),
    .step_i (gen_step),
    .addr_o (rd_addr_o)
  );

  assign wr_bank_o   = wr_bank_q;
  assign wr_addr_o   = wr_addr_q;
  assign rd_bank_o   = rd_bank_q;
  assign out_valid_o = vld_pipe_q[RD_LAT-1];
  assign out_last_o  = last_pipe_q[RD_LAT-1];
  assign done_o      = last_pipe_q[RD_LAT-1];

endmodule
